axi4stream_gen_scheduler: RTL

AXI4STREAM_GEN_SCHEDULER -- requirements
Module: axi4stream_gen_scheduler

---
 rtl/axi4stream_gen_scheduler.sv | 138 +++++++++++++
 1 files changed

// File: rtl/axi4stream_gen_scheduler.sv
// Round-robin burst scheduler in front of an AXI4-Stream generator.
// Requesters post a burst length; the winner's length is handed to the
// generator with a one-cycle gen_start, and the block waits for gen_done.
// Optional watchdog: define AXI4STREAM_GEN_SCHED_TIMEOUT_EN to abort a burst
// whose gen_done never arrives within TIMEOUT_CYCLES WAIT cycles.
//
// Handshake: a request is accepted in the cycle where req_valid[i] and
// req_ready[i] are both high at the rising ACLK edge; req_ready is one-hot,
// combinational, and only ever high in IDLE for the round-robin winner.
module axi4stream_gen_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int LEN_W          = 16,
    parameter int TIMEOUT_CYCLES = 65535,
    localparam int ID_W          = $clog2(NUM_REQ)
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     gen_start,
    output logic [LEN_W-1:0]         gen_len,
    input  logic                     gen_done,
    output logic [ID_W-1:0]          grant_id,
    output logic                     busy,
    output logic [31:0]              burst_cnt,
    output logic                     timeout_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ABORT = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   last_grant;
    logic              sel_found;
    logic [ID_W-1:0]   sel_idx;
    logic [LEN_W-1:0]  sel_len;
    logic              hs;

    // Round-robin search starting just after the previous winner.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            if (!sel_found && req_valid[ID_W'((int'(last_grant) + off) % NUM_REQ)]) begin
                sel_found = 1'b1;
                sel_idx   = ID_W'((int'(last_grant) + off) % NUM_REQ);
            end
        end
    end

    assign sel_len = req_len[sel_idx*LEN_W +: LEN_W];
    assign hs      = (state == IDLE) && sel_found;
    assign busy    = (state != IDLE);

    // One-hot acceptance strobe for the selected requester, IDLE only.
    always_comb begin
        req_ready = '0;
        if (hs) req_ready[sel_idx] = 1'b1;
    end

`ifdef AXI4STREAM_GEN_SCHED_TIMEOUT_EN
    logic [31:0] wd_cnt;
    logic        wd_hit;
    assign wd_hit = (wd_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
    logic        wd_hit;
    assign wd_hit = 1'b0;
`endif

    // Next-state and gen_start decode.
    always_comb begin
        state_nxt = state;
        gen_start = 1'b0;
        case (state)
            IDLE:  if (hs && sel_len != '0) state_nxt = ISSUE;
            ISSUE: begin
                gen_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                // gen_done wins over a watchdog expiry in the same cycle.
                if (gen_done)    state_nxt = IDLE;
                else if (wd_hit) state_nxt = ABORT;
            end
            ABORT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) state <= IDLE;
        else        state <= state_nxt;
    end

    // Grant bookkeeping and completed-burst counter.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            last_grant <= ID_W'(NUM_REQ - 1);
            gen_len    <= '0;
            grant_id   <= '0;
            burst_cnt  <= '0;
        end else begin
            if (hs) begin
                last_grant <= sel_idx;
                // Zero-length requests consume the turn but leave the
                // current burst descriptor untouched.
                if (sel_len != '0) begin
                    gen_len  <= sel_len;
                    grant_id <= sel_idx;
                end
            end
            if (state == WAIT && gen_done) burst_cnt <= burst_cnt + 32'd1;
        end
    end

`ifdef AXI4STREAM_GEN_SCHED_TIMEOUT_EN
    // Watchdog: cleared while entering WAIT, counts WAIT cycles, sticky error.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == ISSUE)     wd_cnt <= '0;
            else if (state == WAIT) wd_cnt <= wd_cnt + 32'd1;
            if (state == WAIT && state_nxt == ABORT) timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule
